// File: rtl/btn_next_conditioner.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// btn_next_conditioner
//
// Turns one raw, bouncy, asynchronous push-button pin into a clean one-cycle
// pulse on `next`. That pulse advances the calculator control FSM
// (Idle1->Input1, Idle2->Input2, Idle3->calculation).
// Signal path: board pin -> two-flop synchroniser -> 4-state debounce FSM with
// a qualification counter -> registered outputs.
//
// Parameters
//   DEBOUNCE_CYCLES  number of consecutive CLK cycles the synchronised input
//                    must differ from the stable level before the change is
//                    accepted (>= 2; board builds use ~1_000_000).
//
// Ports
//   CLK            in   system clock, all state changes on posedge
//   clear          in   synchronous active-high reset, highest priority
//   btn_in         in   raw asynchronous button pin, active-high
//   next           out  one-cycle pulse per accepted press
//   release_pulse  out  one-cycle pulse per accepted release
//   btn_level      out  debounced stable button level
//   state_out      out  debounce state code (RELEASED=00, PRESS_PEND=01,
//                       PRESSED=10, RELEASE_PEND=11)
// -----------------------------------------------------------------------------
module btn_next_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       clear,
  input  logic       btn_in,
  output logic       next,
  output logic       release_pulse,
  output logic       btn_level,
  output logic [1:0] state_out
);

  localparam int CNT_W       = $clog2(DEBOUNCE_CYCLES);
  localparam int SYNC_STAGES = 2;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  // The counter tops out here: it holds DEBOUNCE_CYCLES-1 in the cycle the
  // change is accepted, so it can never wrap.
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED     = 2'b00,
    PRESS_PEND   = 2'b01,
    PRESSED      = 2'b10,
    RELEASE_PEND = 2'b11
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchroniser: stage 0 samples the pin, only the last stage is used.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_reg;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge CLK) begin
          if (clear) sync_reg[gi] <= 1'b0;
          else       sync_reg[gi] <= btn_in;
        end
      end else begin : g_chain
        always_ff @(posedge CLK) begin
          if (clear) sync_reg[gi] <= 1'b0;
          else       sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  logic btn_sync;
  assign btn_sync = sync_reg[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce FSM
  // ---------------------------------------------------------------------------
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             level_reg, level_next;
  logic             press_reg, press_next;
  logic             rel_reg, rel_next;

  always_ff @(posedge CLK) begin
    if (clear) begin
      state_reg <= RELEASED;
      cnt_reg   <= CNT_ZERO;
      level_reg <= 1'b0;
      press_reg <= 1'b0;
      rel_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      level_reg <= level_next;
      press_reg <= press_next;
      rel_reg   <= rel_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    level_next = level_reg;
    press_next = 1'b0;
    rel_next   = 1'b0;

    case (state_reg)
      RELEASED: begin
        // Counter starts at 1: the cycle that detects the change already
        // counts as the first qualifying cycle.
        if (btn_sync) begin
          state_next = PRESS_PEND;
          cnt_next   = CNT_ONE;
        end else begin
          cnt_next   = CNT_ZERO;
        end
      end

      PRESS_PEND: begin
        if (!btn_sync) begin
          state_next = RELEASED;
          cnt_next   = CNT_ZERO;
        end else if (cnt_reg == CNT_MAX) begin
          state_next = PRESSED;
          cnt_next   = CNT_ZERO;
          level_next = 1'b1;
          press_next = 1'b1;
        end else begin
          cnt_next   = cnt_reg + CNT_ONE;
        end
      end

      PRESSED: begin
        // Only leaving PRESSED can produce another press, so a held button
        // never re-triggers `next`.
        if (!btn_sync) begin
          state_next = RELEASE_PEND;
          cnt_next   = CNT_ONE;
        end else begin
          cnt_next   = CNT_ZERO;
        end
      end

      RELEASE_PEND: begin
        if (btn_sync) begin
          state_next = PRESSED;
          cnt_next   = CNT_ZERO;
        end else if (cnt_reg == CNT_MAX) begin
          state_next = RELEASED;
          cnt_next   = CNT_ZERO;
          level_next = 1'b0;
          rel_next   = 1'b1;
        end else begin
          cnt_next   = cnt_reg + CNT_ONE;
        end
      end

      default: begin
        state_next = RELEASED;
        cnt_next   = CNT_ZERO;
        level_next = 1'b0;
      end
    endcase
  end

  assign next          = press_reg;
  assign release_pulse = rel_reg;
  assign btn_level     = level_reg;
  assign state_out     = state_reg;

endmodule

// File: tb/tb_btn_next_conditioner.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_btn_next_conditioner
//
// Directed scenarios with DEBOUNCE_CYCLES=4. The stimulus process changes
// btn_in on a negedge while the cycle count reads c; a change then shows up on
// next/release_pulse at the negedge where the cycle count reads c+6.
// Expected pulses and expected output snapshots are queued up front; a
// separate monitor on the negedge pops pulses when the DUT emits one and pops
// snapshots when their cycle comes round.
// -----------------------------------------------------------------------------
module tb_btn_next_conditioner;

  localparam int D       = 4;
  localparam int LAT     = D + 2;
  localparam int TIMEOUT = 1000;

  logic       CLK = 1'b0;
  logic       clear;
  logic       btn_in;
  logic       next;
  logic       release_pulse;
  logic       btn_level;
  logic [1:0] state_out;

  btn_next_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .CLK           (CLK),
    .clear         (clear),
    .btn_in        (btn_in),
    .next          (next),
    .release_pulse (release_pulse),
    .btn_level     (btn_level),
    .state_out     (state_out)
  );

  always #5 CLK = ~CLK;

  // Number of posedges seen so far.
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int    cyc;
    bit    is_rel;
    string name;
  } pulse_t;

  typedef struct {
    int         cyc;
    logic [1:0] st;
    logic       lvl;
    logic       nx;
    logic       rl;
    string      name;
  } snap_t;

  pulse_t pq[$];
  snap_t  sq[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  bit     done     = 1'b0;

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic wait_to(input int c);
    while (cyc < c) @(negedge CLK);
  endtask

  task automatic set_btn(input int c, input logic v);
    wait_to(c);
    btn_in = v;
  endtask

  task automatic exp_pulse(input int c, input bit rel, input string nm);
    pulse_t p;
    p.cyc = c; p.is_rel = rel; p.name = nm;
    pq.push_back(p);
  endtask

  task automatic exp_snap(input int c, input logic [1:0] st, input logic lvl,
                          input logic nx, input logic rl, input string nm);
    snap_t s;
    s.cyc = c; s.st = st; s.lvl = lvl; s.nx = nx; s.rl = rl; s.name = nm;
    sq.push_back(s);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int b;
    clear  = 1'b1;
    btn_in = 1'b0;
    exp_snap(2, 2'b00, 1'b0, 1'b0, 1'b0, "reset");
    wait_to(3);
    clear = 1'b0;

    // 1. Clean press before edge 10, held 20 cycles.
    b = 9;
    exp_snap(b + 3,        2'b01, 1'b0, 1'b0, 1'b0, "s1_pend");
    exp_snap(b + LAT,      2'b10, 1'b1, 1'b1, 1'b0, "s1_next");
    exp_snap(b + LAT + 1,  2'b10, 1'b1, 1'b0, 1'b0, "s1_held");
    exp_snap(b + 20 + LAT,     2'b00, 1'b0, 1'b0, 1'b1, "s1_rel");
    exp_snap(b + 20 + LAT + 1, 2'b00, 1'b0, 1'b0, 1'b0, "s1_idle");
    exp_pulse(b + LAT,      1'b0, "s1_press");
    exp_pulse(b + 20 + LAT, 1'b1, "s1_release");
    set_btn(b, 1'b1);
    set_btn(b + 20, 1'b0);
    wait_to(40);

    // 2a. Bounce: high for D-1 synced cycles, rejected.
    b = 40;
    exp_snap(b + 4, 2'b01, 1'b0, 1'b0, 1'b0, "s2_pend");
    exp_snap(b + 6, 2'b00, 1'b0, 1'b0, 1'b0, "s2_reject");
    exp_snap(b + 10, 2'b00, 1'b0, 1'b0, 1'b0, "s2_quiet");
    set_btn(b, 1'b1);
    set_btn(b + 3, 1'b0);
    wait_to(55);

    // 2b. Exactly D synced cycles: accepted, then released.
    b = 55;
    exp_snap(b + LAT,     2'b10, 1'b1, 1'b1, 1'b0, "s2b_accept");
    exp_snap(b + 4 + LAT, 2'b00, 1'b0, 1'b0, 1'b1, "s2b_release");
    exp_pulse(b + LAT,     1'b0, "s2b_press");
    exp_pulse(b + 4 + LAT, 1'b1, "s2b_release");
    set_btn(b, 1'b1);
    set_btn(b + 4, 1'b0);
    wait_to(70);

    // 3. Long hold of 100 cycles: one press, one release.
    b = 70;
    exp_snap(b + 50,  2'b10, 1'b1, 1'b0, 1'b0, "s3_hold");
    exp_snap(b + 105, 2'b11, 1'b1, 1'b0, 1'b0, "s3_relpend");
    exp_snap(b + 106, 2'b00, 1'b0, 1'b0, 1'b1, "s3_rel");
    exp_pulse(b + LAT,       1'b0, "s3_press");
    exp_pulse(b + 100 + LAT, 1'b1, "s3_release");
    set_btn(b, 1'b1);
    set_btn(b + 100, 1'b0);
    wait_to(185);

    // 4. Release bounce: low for 2 cycles while pressed, no release pulse.
    b = 185;
    exp_snap(b + 24, 2'b11, 1'b1, 1'b0, 1'b0, "s4_relpend");
    exp_snap(b + 26, 2'b10, 1'b1, 1'b0, 1'b0, "s4_back");
    exp_snap(b + 30 + LAT, 2'b00, 1'b0, 1'b0, 1'b1, "s4_rel");
    exp_pulse(b + LAT,      1'b0, "s4_press");
    exp_pulse(b + 30 + LAT, 1'b1, "s4_release");
    set_btn(b, 1'b1);
    set_btn(b + 20, 1'b0);
    set_btn(b + 22, 1'b1);
    set_btn(b + 30, 1'b0);
    wait_to(230);

    // 5. clear during PRESS_PEND (counter=2) with the button still held:
    //    everything resets, then a fresh press is qualified.
    b = 230;
    exp_snap(b + 4, 2'b01, 1'b0, 1'b0, 1'b0, "s5_pend");
    exp_snap(b + 5, 2'b00, 1'b0, 1'b0, 1'b0, "s5_cleared");
    exp_snap(b + 6, 2'b00, 1'b0, 1'b0, 1'b0, "s5_restart");
    exp_snap(b + 5 + LAT, 2'b10, 1'b1, 1'b1, 1'b0, "s5_next");
    exp_pulse(b + 5 + LAT,  1'b0, "s5_press");
    exp_pulse(b + 20 + LAT, 1'b1, "s5_release");
    set_btn(b, 1'b1);
    wait_to(b + 4);
    clear = 1'b1;
    wait_to(b + 5);
    clear = 1'b0;
    set_btn(b + 20, 1'b0);
    wait_to(260);

    // 6. Three separated presses advancing the calculator FSM three times.
    for (int i = 0; i < 3; i++) begin
      b = 260 + 30 * i;
      exp_pulse(b + LAT,      1'b0, $sformatf("s6_press%0d", i));
      exp_pulse(b + 10 + LAT, 1'b1, $sformatf("s6_release%0d", i));
      set_btn(b, 1'b1);
      set_btn(b + 10, 1'b0);
    end
    wait_to(345);
    done = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  pulse_t mp;
  snap_t  ms;

  always @(negedge CLK) begin
    if (next || release_pulse) begin
      n_checks++;
      if (pq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse @%0d: got next=%0b release_pulse=%0b, required none",
                 cyc, next, release_pulse);
      end else begin
        mp = pq.pop_front();
        if (next && release_pulse) begin
          n_fail++;
          $display("FAIL %s @%0d: got next=1 and release_pulse=1 together, required only one",
                   mp.name, cyc);
        end else if (mp.cyc != cyc || mp.is_rel != release_pulse) begin
          n_fail++;
          $display("FAIL %s: got %s at cycle %0d, required %s at cycle %0d", mp.name,
                   release_pulse ? "release" : "press", cyc,
                   mp.is_rel ? "release" : "press", mp.cyc);
        end else begin
          $display("ok   %s: %s at cycle %0d", mp.name, mp.is_rel ? "release" : "press", cyc);
        end
      end
    end

    while (sq.size() > 0 && sq[0].cyc <= cyc) begin
      ms = sq.pop_front();
      n_checks++;
      if (state_out !== ms.st || btn_level !== ms.lvl || next !== ms.nx ||
          release_pulse !== ms.rl) begin
        n_fail++;
        $display("FAIL %s @%0d: got state=%b lvl=%b next=%b rel=%b, required state=%b lvl=%b next=%b rel=%b",
                 ms.name, cyc, state_out, btn_level, next, release_pulse,
                 ms.st, ms.lvl, ms.nx, ms.rl);
      end else begin
        $display("ok   %s @%0d: state=%b lvl=%b next=%b rel=%b",
                 ms.name, cyc, state_out, btn_level, next, release_pulse);
      end
    end

    if (done) begin
      n_checks++;
      if (pq.size() != 0 || sq.size() != 0) begin
        n_fail++;
        $display("FAIL leftover_expectations: got %0d pulses and %0d snapshots unconsumed, required 0",
                 pq.size(), sq.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end else if (cyc > TIMEOUT) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: got cycle %0d, required completion by %0d", cyc, TIMEOUT);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

endmodule
